// File: rtl/hazard_if.sv
// hazard_if: ID-stage instruction info in, forwarding selects and stall controls out
interface hazard_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_re1;
  logic        id_re2;
  logic [4:0]  id_rd;
  logic        id_we;
  logic        id_is_load;
  logic        flush;
  logic [1:0]  rD1_sel;
  logic [1:0]  rD2_sel;
  logic        stall_pc;
  logic        stall_if_id;
  logic        flush_id_ex;
  logic [31:0] stall_cnt;
  modport master (
    output id_valid, id_rs1, id_rs2, id_re1, id_re2, id_rd, id_we, id_is_load, flush,
    input  rD1_sel, rD2_sel, stall_pc, stall_if_id, flush_id_ex, stall_cnt
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_re1, id_re2, id_rd, id_we, id_is_load, flush,
    output rD1_sel, rD2_sel, stall_pc, stall_if_id, flush_id_ex, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX/MEM forwarding selects and one-cycle load-use stall (stall counter under HAZARD_STALL_CNT_EN)
module hazard_ctrl (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);
  localparam logic [1:0] NO_HAZARD       = 2'b00;
  localparam logic [1:0] HAZARD_1        = 2'b01;
  localparam logic [1:0] HAZARD_2        = 2'b10;
  localparam logic [1:0] LOAD_USE_HAZARD = 2'b11;
  typedef enum logic {RUN, STALL} state_t;
  state_t     state_q, state_d;
  logic       ex_v_q, ex_we_q, ex_ld_q, mem_v_q, mem_we_q, mem_ld_q;
  logic [4:0] ex_rd_q, mem_rd_q;
  logic [1:0] sel1_q, sel2_q, sel1_d, sel2_d, mem_sel;
  logic       ex1, ex2, mem1, mem2, lu, stall, fid, bubble;
  function automatic logic hit(input logic re, input logic [4:0] rs, input logic v,
                               input logic we, input logic [4:0] rd);
    return re && rs != 5'd0 && v && we && rd == rs;
  endfunction
  always_comb begin
    ex1     = hit(hz.id_re1, hz.id_rs1, ex_v_q, ex_we_q, ex_rd_q);
    ex2     = hit(hz.id_re2, hz.id_rs2, ex_v_q, ex_we_q, ex_rd_q);
    mem1    = hit(hz.id_re1, hz.id_rs1, mem_v_q, mem_we_q, mem_rd_q);
    mem2    = hit(hz.id_re2, hz.id_rs2, mem_v_q, mem_we_q, mem_rd_q);
    lu      = hz.id_valid && ex_v_q && ex_ld_q && (ex1 || ex2);
    stall   = !rst && !hz.flush && lu && state_q == RUN;
    fid     = !rst && (hz.flush || lu);
    bubble  = fid || !hz.id_valid;
    mem_sel = (state_q == STALL && mem_ld_q) ? LOAD_USE_HAZARD : HAZARD_2;
    sel1_d  = bubble ? NO_HAZARD : ex1 ? HAZARD_1 : mem1 ? mem_sel : NO_HAZARD;
    sel2_d  = bubble ? NO_HAZARD : ex2 ? HAZARD_1 : mem2 ? mem_sel : NO_HAZARD;
    state_d = stall ? STALL : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      ex_v_q   <= 1'b0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      ex_rd_q  <= 5'd0;
      mem_v_q  <= 1'b0;
      mem_we_q <= 1'b0;
      mem_ld_q <= 1'b0;
      mem_rd_q <= 5'd0;
      sel1_q   <= NO_HAZARD;
      sel2_q   <= NO_HAZARD;
    end else begin
      state_q  <= state_d;
      ex_v_q   <= !bubble;
      ex_we_q  <= hz.id_we;
      ex_ld_q  <= hz.id_is_load;
      ex_rd_q  <= hz.id_rd;
      mem_v_q  <= ex_v_q;
      mem_we_q <= ex_we_q;
      mem_ld_q <= ex_ld_q;
      mem_rd_q <= ex_rd_q;
      sel1_q   <= sel1_d;
      sel2_q   <= sel2_d;
    end
  end
  assign hz.rD1_sel     = sel1_q;
  assign hz.rD2_sel     = sel2_q;
  assign hz.stall_pc    = stall;
  assign hz.stall_if_id = stall;
  assign hz.flush_id_ex = fid;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (stall && !(&cnt_q)) cnt_q <= cnt_q + 32'd1;
  end
  assign hz.stall_cnt = cnt_q;
`else
  assign hz.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven check of forwarding, load-use stall, flush and reset
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  hazard_if hz ();
  hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz));
`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef struct {
    logic v; logic [4:0] rs1; logic re1; logic [4:0] rs2; logic re2;
    logic [4:0] rd; logic we; logic ld; logic fl; logic r;
    logic st; logic fid; logic [1:0] s1; logic [1:0] s2;
  } vec_t;
  typedef struct { logic [1:0] s1; logic [1:0] s2; logic [31:0] cnt; } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_cnt = 32'd0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input int v, input int rs1, input int re1, input int rs2,
                              input int re2, input int rd, input int we, input int ld,
                              input int fl, input int r, input int st, input int fid,
                              input int s1, input int s2);
    vec_t m;
    m.v = v != 0; m.rs1 = 5'(rs1); m.re1 = re1 != 0; m.rs2 = 5'(rs2); m.re2 = re2 != 0;
    m.rd = 5'(rd); m.we = we != 0; m.ld = ld != 0; m.fl = fl != 0; m.r = r != 0;
    m.st = st != 0; m.fid = fid != 0; m.s1 = 2'(s1); m.s2 = 2'(s2);
    return m;
  endfunction
  initial begin
    vec_t t;
    exp_t e;
    rst = 1'b1;
    hz.id_valid = 1'b0; hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_re1 = 1'b0; hz.id_re2 = 1'b0;
    hz.id_rd = 5'd0; hz.id_we = 1'b0; hz.id_is_load = 1'b0; hz.flush = 1'b0;
    //                 v rs1 re1 rs2 re2 rd we ld fl r   st fid s1 s2
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1,  5, 1,  9, 1, 0, 0, 0,  0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0,  0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0,  6, 1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 1,  0, 0, 10, 1, 0, 0, 0,  0, 0, 2, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 10, 1,  5, 1, 0, 0, 0,  0, 0, 0, 2));
    tbl.push_back(mk(1, 5, 1,  5, 1,  0, 0, 0, 0, 0,  0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0,  0, 0, 11, 1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 12, 1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1,12, 1, 11, 1, 13, 1, 0, 0, 0,  0, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0,  0, 0,  0, 1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 13, 0, 14, 1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0,  7, 1, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 7, 1, 14, 1, 15, 1, 0, 0, 0,  1, 1, 0, 0));
    tbl.push_back(mk(1, 7, 1, 14, 1, 15, 1, 0, 0, 0,  0, 0, 3, 0));
    tbl.push_back(mk(1, 7, 1,  0, 0, 16, 1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0,  8, 1, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 17, 1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  8, 1, 18, 1, 0, 0, 0,  0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0,  0, 0,  3, 1, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  3, 1, 19, 1, 0, 1, 0,  0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,  3, 1, 20, 1, 0, 0, 0,  0, 0, 0, 2));
    tbl.push_back(mk(1,20, 1,  0, 0,  0, 0, 0, 1, 0,  0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0,  4, 1, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 1,  0, 0, 21, 1, 0, 0, 0,  1, 1, 0, 0));
    tbl.push_back(mk(1, 4, 1,  0, 0, 21, 1, 0, 0, 1,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0,  4, 1, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 1,  0, 0, 21, 1, 0, 0, 1,  0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 1,  0, 0, 21, 1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0,  2, 1, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  2, 1, 22, 1, 0, 0, 0,  1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,  2, 1, 22, 1, 0, 1, 0,  0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,  2, 1, 22, 1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0,  2, 1, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  2, 1, 23, 1, 0, 0, 0,  1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,  2, 1, 23, 1, 0, 0, 0,  0, 0, 0, 3));
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      @(negedge clk);
      rst = t.r;
      hz.id_valid = t.v; hz.id_rs1 = t.rs1; hz.id_re1 = t.re1; hz.id_rs2 = t.rs2;
      hz.id_re2 = t.re2; hz.id_rd = t.rd; hz.id_we = t.we; hz.id_is_load = t.ld;
      hz.flush = t.fl;
      #1;
      chk($sformatf("stall_pc[%0d]", i), 32'(hz.stall_pc), 32'(t.st));
      chk($sformatf("stall_if_id[%0d]", i), 32'(hz.stall_if_id), 32'(t.st));
      chk($sformatf("flush_id_ex[%0d]", i), 32'(hz.flush_id_ex), 32'(t.fid));
      exp_cnt = t.r ? 32'd0 : (CNT_EN && t.st && exp_cnt != 32'hFFFF_FFFF) ? exp_cnt + 32'd1 : exp_cnt;
      sb.push_back('{s1: t.s1, s2: t.s2, cnt: exp_cnt});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("rD1_sel[%0d]", i), 32'(hz.rD1_sel), 32'(e.s1));
      chk($sformatf("rD2_sel[%0d]", i), 32'(hz.rD2_sel), 32'(e.s2));
      chk($sformatf("stall_cnt[%0d]", i), hz.stall_cnt, e.cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: id_valid  in  1  a decoded instruction is present in ID.
REQ-004 SHALL have ports: id_rs1, id_rs2  in  5 each  source register numbers.
REQ-005 SHALL have ports: id_re1, id_re2  in  1 each  the instruction reads rs1 / rs2.
REQ-006 SHALL have ports: id_rd  in  5  destination register; id_we  in  1  writes rd; id_is_load  in  1  is a load.
REQ-007 SHALL have ports: flush  in  1  taken branch or jump resolved in EX; kills the instructions in ID and IF.
REQ-008 SHALL have ports: rD1_sel, rD2_sel  out  2 each  registered operand-mux selects for the instruction now in EX.
REQ-009 SHALL have ports: stall_pc, stall_if_id  out  1 each  hold PC and the IF/ID register; flush_id_ex  out  1  insert a bubble into ID/EX.
REQ-010 SHALL have ports: stall_cnt  out  32  count of load-use stall cycles.
REQ-011 SHALL use the select encodings NO_HAZARD=2'b00, HAZARD_1=2'b01 (EX result), HAZARD_2=2'b10 (MEM result), and LOAD_USE_HAZARD=2'b11 (MEM result after a stall).

Function
REQ-012 SHALL hold two internal tag stages, EX and MEM, each holding {valid, rd, we, is_load}; tags shift ID->EX->MEM every cycle.
REQ-013 SHALL load a bubble (valid=0) into the EX tag when flush_id_ex=1 or id_valid=0.
REQ-014 SHALL raise a forward-match for a source only if: its read-enable=1, rs!=0, the stage is valid, we=1, and rd==rs.
REQ-015 SHALL compute each next select in ID with this priority: an EX-stage match gives HAZARD_1; otherwise a MEM-stage match gives HAZARD_2 (or LOAD_USE_HAZARD when rule REQ-018 applies); otherwise NO_HAZARD.
REQ-016 SHALL register each select into rD1_sel / rD2_sel together with the EX tag, so each select is valid in the same cycle its instruction occupies EX.
REQ-017 SHALL detect a load-use hazard when the EX tag is a valid load and it matches either source of a valid ID instruction.
REQ-018 SHALL handle load-use with a 2-state FSM:
  - RUN --hazard--> STALL: stall_pc=1, stall_if_id=1, flush_id_ex=1, all combinational in the detection cycle.
  - STALL -> RUN after exactly one cycle; the held instruction reaches EX with select LOAD_USE_HAZARD for each source that matched the load.
REQ-019 SHALL limit each load-use to exactly one stall cycle; back-to-back dependent instructions on the same load SHALL NOT stall again.
REQ-020 SHALL NOT raise a hazard in STALL for the bubble now in EX (bubble tag valid=0).
REQ-021 SHALL give flush priority over a load-use hazard in the same cycle:
  - no stall; flush_id_ex=1; FSM goes to RUN.
  - flush asserted in STALL also returns the FSM to RUN.
REQ-022 SHALL, when both sources match, select each source independently (e.g. rD1_sel=HAZARD_1 and rD2_sel=HAZARD_2).
REQ-023 SHALL increment stall_cnt once per cycle in which stall_pc=1, saturating at 32'hFFFF_FFFF.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, clear:
  - FSM to RUN; both tag stages invalid;
  - rD1_sel=rD2_sel=NO_HAZARD; stall_cnt=0.
REQ-025 SHALL hold stall_pc, stall_if_id and flush_id_ex at 0 while rst=1, including when rst is asserted mid-stall.

Configuration
REQ-026 SHALL compile the stall_cnt counter only when macro HAZARD_STALL_CNT_EN is defined.
REQ-027 SHALL, without HAZARD_STALL_CNT_EN, keep the stall_cnt port and tie it to 0, with no counter register; all other behaviour SHALL be identical.

Verification
REQ-028 SHALL check EX forwarding: EX add rd=5, ID reads rs2=5 -> next cycle rD2_sel=01, rD1_sel=00, no stall.
REQ-029 SHALL check MEM forwarding and priority:
  - MEM rd=5, EX rd=6, ID rs1=5 -> rD1_sel=10.
  - EX and MEM both rd=5 -> rD1_sel=01.
REQ-030 SHALL check load-use: EX lw rd=7, ID rs1=7 -> one cycle of stall_pc=stall_if_id=flush_id_ex=1, then rD1_sel=11; stall_cnt=1.
REQ-031 SHALL check register x0: EX writes rd=0, ID rs1=0 with re1=1 -> rD1_sel=00, no stall.
REQ-032 SHALL check flush against load-use: EX lw rd=3, ID rs2=3, flush=1 in the same cycle -> stall_pc=0, flush_id_ex=1, stall_cnt unchanged.
REQ-033 SHALL check reset mid-stall: rst=1 in STALL -> next edge all outputs 0 and FSM in RUN; with HAZARD_STALL_CNT_EN undefined, stall_cnt stays 0 throughout.
